// File: rtl/l2_miss_queue_pkg.sv
// l2_miss_queue_pkg
// Shared types for the L2 pending-miss queue.
//   mq_state_t   : lifecycle of one queue entry
//   mq_ptr_width : bit width of a circular-buffer pointer for a given depth
// The entry record (addr, payload, data) is declared inside l2_miss_queue,
// because its field widths are parameters of that module.
package l2_miss_queue_pkg;

    typedef enum logic [2:0] {
        MQ_FREE,
        MQ_WAIT_ISSUE,
        MQ_WAIT_FILL,
        MQ_READY,
        MQ_COLLIDED
    } mq_state_t;

    function automatic int mq_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/l2_miss_queue_cam.sv
// l2_miss_queue_cam
// Parallel compare of an incoming miss address against every queue entry.
// Ports:
//   i_key    in   address of the miss being enqueued
//   i_addrs  in   line address held in each entry
//   i_live   in   entry still owns an outstanding or unrestarted fill
//   o_match  out  one bit per entry: live and same line
module l2_miss_queue_cam #(
    parameter int QUEUE_DEPTH = 8,
    parameter int ADDR_WIDTH  = 26
) (
    input  logic [ADDR_WIDTH-1:0]                  i_key,
    input  logic [QUEUE_DEPTH-1:0][ADDR_WIDTH-1:0] i_addrs,
    input  logic [QUEUE_DEPTH-1:0]                 i_live,
    output logic [QUEUE_DEPTH-1:0]                 o_match
);

    always_comb begin
        o_match = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            o_match[i] = i_live[i] && (i_addrs[i] == i_key);
        end
    end

endmodule

// File: rtl/l2_miss_queue.sv
// l2_miss_queue
// Pending-miss queue between the L2 update stage and the AXI bus interface.
// Misses are held in a circular buffer, their line fills are issued in order,
// and each miss is handed back for restart (with its fill data) in enqueue
// order.
//
// Optional feature macro: L2_MISS_QUEUE_COLLIDE_EN
//   defined   : a miss to a line already owned by a live entry is merged
//               (COLLIDED), requests no fill and restarts with collided=1
//   undefined : every miss issues its own fill, restart_collided tied 0
//
// Ports:
//   clk, reset (async, active low)
//   enq_valid/enq_ready/enq_addr/enq_payload           miss intake
//   fill_req_valid/fill_req_ready/fill_req_addr        fill request to bus
//   fill_rsp_valid/fill_rsp_data                       in-order fill data
//   restart_valid/restart_ready/restart_addr/
//   restart_payload/restart_data/restart_collided      restart to pipeline
//   occupancy                                          valid entry count
//
// Entry states:
//   state          | meaning
//   MQ_FREE        | slot unused
//   MQ_WAIT_ISSUE  | miss held, fill request not yet accepted by bus
//   MQ_WAIT_FILL   | fill request accepted, waiting for line data
//   MQ_READY       | line data held, waiting for restart handshake
//   MQ_COLLIDED    | merged with an earlier miss to the same line
module l2_miss_queue
    import l2_miss_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH   = 8,
    parameter int ADDR_WIDTH    = 26,
    parameter int PAYLOAD_WIDTH = 128,
    parameter int LINE_WIDTH    = 512
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enq_valid,
    output logic                           enq_ready,
    input  logic [ADDR_WIDTH-1:0]          enq_addr,
    input  logic [PAYLOAD_WIDTH-1:0]       enq_payload,
    output logic                           fill_req_valid,
    input  logic                           fill_req_ready,
    output logic [ADDR_WIDTH-1:0]          fill_req_addr,
    input  logic                           fill_rsp_valid,
    input  logic [LINE_WIDTH-1:0]          fill_rsp_data,
    output logic                           restart_valid,
    input  logic                           restart_ready,
    output logic [ADDR_WIDTH-1:0]          restart_addr,
    output logic [PAYLOAD_WIDTH-1:0]       restart_payload,
    output logic [LINE_WIDTH-1:0]          restart_data,
    output logic                           restart_collided,
    output logic [$clog2(QUEUE_DEPTH):0]   occupancy
);

    localparam int PTR_W = mq_ptr_width(QUEUE_DEPTH);

    typedef logic [PTR_W-1:0] mq_ptr_t;
    typedef logic [PTR_W:0]   mq_occ_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]    addr;
        logic [PAYLOAD_WIDTH-1:0] payload;
        logic [LINE_WIDTH-1:0]    data;
    } mq_entry_t;

    mq_state_t r_state [QUEUE_DEPTH];
    mq_entry_t r_entry [QUEUE_DEPTH];
    mq_ptr_t   r_tail;
    mq_ptr_t   r_issue;
    mq_ptr_t   r_fill;
    mq_ptr_t   r_head;
    mq_occ_t   r_occ;

    mq_state_t w_enq_state;
    logic      w_issue_found;
    mq_ptr_t   w_issue_idx;
    logic      w_fill_found;
    mq_ptr_t   w_fill_idx;
    mq_ptr_t   w_scan_i;
    mq_ptr_t   w_scan_f;
    logic      w_enq;
    logic      w_issue_hs;
    logic      w_fill_wr;
    logic      w_head_ready;
    logic      w_restart;

    // Issue and fill pointers skip collided slots: each searches forward from
    // its pointer for the oldest entry in its state. Entries reach WAIT_ISSUE
    // and WAIT_FILL in age order, so the first hit is always the right one,
    // however many merged entries sit between them.
    always_comb begin
        w_issue_found = 1'b0;
        w_issue_idx   = r_issue;
        w_fill_found  = 1'b0;
        w_fill_idx    = r_fill;
        w_scan_i      = r_issue;
        w_scan_f      = r_fill;
        for (int k = QUEUE_DEPTH - 1; k >= 0; k--) begin
            w_scan_i = r_issue + mq_ptr_t'(k);
            w_scan_f = r_fill + mq_ptr_t'(k);
            if (r_state[w_scan_i] == MQ_WAIT_ISSUE) begin
                w_issue_found = 1'b1;
                w_issue_idx   = w_scan_i;
            end
            if (r_state[w_scan_f] == MQ_WAIT_FILL) begin
                w_fill_found = 1'b1;
                w_fill_idx   = w_scan_f;
            end
        end
    end

    assign enq_ready    = (r_occ != mq_occ_t'(QUEUE_DEPTH));
    assign w_enq        = enq_valid && enq_ready;
    assign w_issue_hs   = w_issue_found && fill_req_ready;
    assign w_fill_wr    = fill_rsp_valid && w_fill_found;
    assign w_head_ready = (r_state[r_head] == MQ_READY) ||
                          (r_state[r_head] == MQ_COLLIDED);
    assign w_restart    = w_head_ready && restart_ready;

`ifdef L2_MISS_QUEUE_COLLIDE_EN
    logic [QUEUE_DEPTH-1:0]                 w_live;
    logic [QUEUE_DEPTH-1:0]                 w_match;
    logic [QUEUE_DEPTH-1:0][ADDR_WIDTH-1:0] w_addrs;

    // Collided entries never own a fill, so they are not merge targets.
    always_comb begin
        w_live  = '0;
        w_addrs = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            w_live[i]  = (r_state[i] == MQ_WAIT_ISSUE) ||
                         (r_state[i] == MQ_WAIT_FILL)  ||
                         (r_state[i] == MQ_READY);
            w_addrs[i] = r_entry[i].addr;
        end
    end

    l2_miss_queue_cam #(
        .QUEUE_DEPTH (QUEUE_DEPTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_cam (
        .i_key   (enq_addr),
        .i_addrs (w_addrs),
        .i_live  (w_live),
        .o_match (w_match)
    );

    assign w_enq_state      = (|w_match) ? MQ_COLLIDED : MQ_WAIT_ISSUE;
    assign restart_collided = w_head_ready && (r_state[r_head] == MQ_COLLIDED);
`else
    assign w_enq_state      = MQ_WAIT_ISSUE;
    assign restart_collided = 1'b0;
`endif

    // The four events always target distinct slots (each needs a different
    // entry state), so they can all update in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_state[i] <= MQ_FREE;
            end
            r_tail  <= '0;
            r_issue <= '0;
            r_fill  <= '0;
            r_head  <= '0;
            r_occ   <= '0;
        end else begin
            if (w_enq) begin
                r_state[r_tail] <= w_enq_state;
                r_tail          <= r_tail + mq_ptr_t'(1);
            end
            if (w_issue_hs) begin
                r_state[w_issue_idx] <= MQ_WAIT_FILL;
                r_issue              <= w_issue_idx + mq_ptr_t'(1);
            end
            if (w_fill_wr) begin
                r_state[w_fill_idx] <= MQ_READY;
                r_fill              <= w_fill_idx + mq_ptr_t'(1);
            end
            if (w_restart) begin
                r_state[r_head] <= MQ_FREE;
                r_head          <= r_head + mq_ptr_t'(1);
            end
            r_occ <= r_occ + mq_occ_t'(w_enq) - mq_occ_t'(w_restart);
        end
    end

    // Payload storage is not reset; every output that exposes it is gated by
    // its valid, so stale contents never leave the block.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_entry[r_tail].addr    <= enq_addr;
            r_entry[r_tail].payload <= enq_payload;
        end
        if (w_fill_wr) begin
            r_entry[w_fill_idx].data <= fill_rsp_data;
        end
    end

    assign fill_req_valid  = w_issue_found;
    assign fill_req_addr   = w_issue_found ? r_entry[w_issue_idx].addr : '0;
    assign restart_valid   = w_head_ready;
    assign restart_addr    = w_head_ready ? r_entry[r_head].addr : '0;
    assign restart_payload = w_head_ready ? r_entry[r_head].payload : '0;
    assign restart_data    = w_head_ready ? r_entry[r_head].data : '0;
    assign occupancy       = r_occ;

    // A fill response with no entry waiting for it is a bus protocol error;
    // the data is dropped.
    fill_rsp_has_target: assert property (
        @(posedge clk) disable iff (!reset) fill_rsp_valid |-> w_fill_found
    );

endmodule

// File: tb/tb_l2_miss_queue.sv
module tb_l2_miss_queue;

`ifdef L2_MISS_QUEUE_COLLIDE_EN
    localparam bit COLLIDE = 1'b1;
`else
    localparam bit COLLIDE = 1'b0;
`endif

    localparam int D  = 8;
    localparam int AW = 26;
    localparam int PW = 128;
    localparam int LW = 512;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enq_valid = 1'b0;
    logic          enq_ready;
    logic [AW-1:0] enq_addr = '0;
    logic [PW-1:0] enq_payload = '0;
    logic          fill_req_valid;
    logic          fill_req_ready = 1'b0;
    logic [AW-1:0] fill_req_addr;
    logic          fill_rsp_valid = 1'b0;
    logic [LW-1:0] fill_rsp_data = '0;
    logic          restart_valid;
    logic          restart_ready = 1'b0;
    logic [AW-1:0] restart_addr;
    logic [PW-1:0] restart_payload;
    logic [LW-1:0] restart_data;
    logic          restart_collided;
    logic [3:0]    occupancy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [PW-1:0] payload;
        bit            collided;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] fillq[$];
    logic [AW-1:0] busq[$];

    l2_miss_queue #(
        .QUEUE_DEPTH   (D),
        .ADDR_WIDTH    (AW),
        .PAYLOAD_WIDTH (PW),
        .LINE_WIDTH    (LW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enq_valid        (enq_valid),
        .enq_ready        (enq_ready),
        .enq_addr         (enq_addr),
        .enq_payload      (enq_payload),
        .fill_req_valid   (fill_req_valid),
        .fill_req_ready   (fill_req_ready),
        .fill_req_addr    (fill_req_addr),
        .fill_rsp_valid   (fill_rsp_valid),
        .fill_rsp_data    (fill_rsp_data),
        .restart_valid    (restart_valid),
        .restart_ready    (restart_ready),
        .restart_addr     (restart_addr),
        .restart_payload  (restart_payload),
        .restart_data     (restart_data),
        .restart_collided (restart_collided),
        .occupancy        (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        logic [31:0] w;
        w = {6'h2A, a};
        return {16{w}};
    endfunction

    function automatic logic [PW-1:0] rand_payload();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enq_valid      = 1'b0;
        enq_addr       = '0;
        enq_payload    = '0;
        fill_req_ready = 1'b0;
        fill_rsp_valid = 1'b0;
        fill_rsp_data  = '0;
        restart_ready  = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        #2 reset = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready got=%b exp=1", enq_ready); end
        checks++;
        if (fill_req_valid !== 1'b0) begin errors++; $display("FAIL reset_fill_req_valid got=%b exp=0", fill_req_valid); end
        checks++;
        if (restart_valid !== 1'b0) begin errors++; $display("FAIL reset_restart_valid got=%b exp=0", restart_valid); end
        checks++;
        if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        checks++;
        if (restart_collided !== 1'b0 || restart_addr !== '0 || fill_req_addr !== '0)
        begin errors++; $display("FAIL reset_data_outputs got=%b/%h/%h exp=0/0/0", restart_collided, restart_addr, fill_req_addr); end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_miss();
        logic [PW-1:0] pay;
        logic [LW-1:0] aa;
        pay = rand_payload();
        aa  = {64{8'hAA}};
        apply_reset();
        // cycle 0
        enq_valid = 1'b1; enq_addr = 26'h100; enq_payload = pay;
        checks++;
        if (fill_req_valid !== 1'b0) begin errors++; $display("FAIL single_req_early got=%b exp=0", fill_req_valid); end
        tick();
        // cycle 1
        enq_valid = 1'b0; fill_req_ready = 1'b1;
        checks++;
        if (fill_req_valid !== 1'b1 || fill_req_addr !== 26'h100)
        begin errors++; $display("FAIL single_req got=%b/%h exp=1/100", fill_req_valid, fill_req_addr); end
        checks++;
        if (occupancy !== 4'd1) begin errors++; $display("FAIL single_occ1 got=%0d exp=1", occupancy); end
        tick();
        // cycles 2..4
        fill_req_ready = 1'b0;
        checks++;
        if (fill_req_valid !== 1'b0) begin errors++; $display("FAIL single_req_once got=%b exp=0", fill_req_valid); end
        repeat (3) tick();
        // cycle 5
        fill_rsp_valid = 1'b1; fill_rsp_data = aa;
        checks++;
        if (restart_valid !== 1'b0) begin errors++; $display("FAIL single_restart_early got=%b exp=0", restart_valid); end
        tick();
        // cycle 6
        fill_rsp_valid = 1'b0; fill_rsp_data = '0; restart_ready = 1'b1;
        checks++;
        if (restart_valid !== 1'b1 || restart_addr !== 26'h100 || restart_collided !== 1'b0)
        begin errors++; $display("FAIL single_restart got=%b/%h/%b exp=1/100/0", restart_valid, restart_addr, restart_collided); end
        checks++;
        if (restart_data !== aa || restart_payload !== pay)
        begin errors++; $display("FAIL single_restart_data got=%h exp=%h", restart_data, aa); end
        tick();
        restart_ready = 1'b0;
        checks++;
        if (occupancy !== 4'd0 || restart_valid !== 1'b0)
        begin errors++; $display("FAIL single_drain got=%0d/%b exp=0/0", occupancy, restart_valid); end
    endtask

    task automatic test_full_queue();
        apply_reset();
        for (int i = 0; i < D; i++) begin
            enq_valid = 1'b1; enq_addr = 26'h300 + AW'(i); enq_payload = rand_payload();
            checks++;
            if (enq_ready !== 1'b1) begin errors++; $display("FAIL full_enq_ready_%0d got=%b exp=1", i, enq_ready); end
            tick();
        end
        enq_addr = 26'h3FF;
        checks++;
        if (enq_ready !== 1'b0 || occupancy !== 4'd8)
        begin errors++; $display("FAIL full_after_8 got=%b/%0d exp=0/8", enq_ready, occupancy); end
        tick();
        enq_valid = 1'b0;
        checks++;
        if (occupancy !== 4'd8) begin errors++; $display("FAIL full_9th_rejected got=%0d exp=8", occupancy); end
        for (int j = 0; j < D; j++) begin
            fill_req_ready = 1'b1;
            checks++;
            if (fill_req_valid !== 1'b1 || fill_req_addr !== 26'h300 + AW'(j))
            begin errors++; $display("FAIL full_req_%0d got=%b/%h exp=1/%h", j, fill_req_valid, fill_req_addr, 26'h300 + AW'(j)); end
            tick();
            fill_req_ready = 1'b0; fill_rsp_valid = 1'b1; fill_rsp_data = line_of(26'h300 + AW'(j));
            tick();
            fill_rsp_valid = 1'b0; restart_ready = 1'b1;
            checks++;
            if (restart_valid !== 1'b1 || restart_addr !== 26'h300 + AW'(j) || restart_data !== line_of(26'h300 + AW'(j)))
            begin errors++; $display("FAIL full_restart_%0d got=%b/%h exp=1/%h", j, restart_valid, restart_addr, 26'h300 + AW'(j)); end
            tick();
            restart_ready = 1'b0;
            if (j == 0) begin
                checks++;
                if (enq_ready !== 1'b1 || occupancy !== 4'd7)
                begin errors++; $display("FAIL full_reopen got=%b/%0d exp=1/7", enq_ready, occupancy); end
            end
        end
        checks++;
        if (occupancy !== 4'd0) begin errors++; $display("FAIL full_drained got=%0d exp=0", occupancy); end
    endtask

    task automatic test_collision();
        logic [PW-1:0] p0, p1;
        logic [LW-1:0] d1, d2;
        p0 = rand_payload(); p1 = rand_payload();
        d1 = {16{32'h1111_0200}}; d2 = {16{32'h2222_0200}};
        apply_reset();
        enq_valid = 1'b1; enq_addr = 26'h200; enq_payload = p0;
        tick();
        enq_payload = p1; fill_req_ready = 1'b1;
        checks++;
        if (fill_req_valid !== 1'b1 || fill_req_addr !== 26'h200)
        begin errors++; $display("FAIL coll_req0 got=%b/%h exp=1/200", fill_req_valid, fill_req_addr); end
        tick();
        enq_valid = 1'b0;
        checks++;
        if (fill_req_valid !== !COLLIDE) begin errors++; $display("FAIL coll_req1 got=%b exp=%b", fill_req_valid, !COLLIDE); end
        tick();
        fill_req_ready = 1'b0; fill_rsp_valid = 1'b1; fill_rsp_data = d1;
        checks++;
        if (fill_req_valid !== 1'b0) begin errors++; $display("FAIL coll_req_extra got=%b exp=0", fill_req_valid); end
        tick();
        fill_rsp_valid = !COLLIDE; fill_rsp_data = d2; restart_ready = 1'b1;
        checks++;
        if (restart_valid !== 1'b1 || restart_payload !== p0 || restart_collided !== 1'b0 || restart_data !== d1)
        begin errors++; $display("FAIL coll_restart0 got=%b/%b/%h exp=1/0/%h", restart_valid, restart_collided, restart_data, d1); end
        tick();
        fill_rsp_valid = 1'b0;
        checks++;
        if (restart_valid !== 1'b1 || restart_payload !== p1 || restart_collided !== COLLIDE || restart_addr !== 26'h200)
        begin errors++; $display("FAIL coll_restart1 got=%b/%b exp=1/%b", restart_valid, restart_collided, COLLIDE); end
        tick();
        restart_ready = 1'b0;
        checks++;
        if (occupancy !== 4'd0 || restart_valid !== 1'b0)
        begin errors++; $display("FAIL coll_drain got=%0d/%b exp=0/0", occupancy, restart_valid); end
    endtask

    // Random traffic against a queue model; narrow=1 draws addresses from a
    // four-line pool so merging is exercised.
    task automatic test_wrap(input int n, input bit narrow);
        int            sent, done, cyc;
        bit            coll;
        logic          prev_fv, prev_fr, prev_rv, prev_rr;
        logic [AW-1:0] prev_faddr, prev_raddr, a;
        logic [PW-1:0] prev_rpay;
        logic [LW-1:0] prev_rdata;
        exp_t          e;
        sent = 0; done = 0; cyc = 0;
        prev_fv = 1'b0; prev_fr = 1'b0; prev_rv = 1'b0; prev_rr = 1'b0;
        prev_faddr = '0; prev_raddr = '0; prev_rpay = '0; prev_rdata = '0;
        exp_q.delete(); fillq.delete(); busq.delete();
        apply_reset();
        while (done < n && cyc < 3000) begin
            enq_valid      = (sent < n) && ($urandom_range(0, 3) != 0);
            enq_addr       = narrow ? AW'(26'h40 + $urandom_range(0, 3)) : AW'(sent);
            enq_payload    = rand_payload();
            fill_req_ready = ($urandom_range(0, 2) == 0);
            restart_ready  = ($urandom_range(0, 2) == 0);
            fill_rsp_valid = (busq.size() > 0) && ($urandom_range(0, 1) == 0);
            fill_rsp_data  = fill_rsp_valid ? line_of(busq[0]) : '0;
            #1;
            checks++;
            if (occupancy !== 4'(exp_q.size()) || enq_ready !== (exp_q.size() != D))
            begin errors++; $display("FAIL wrap_occ got=%0d/%b exp=%0d", occupancy, enq_ready, exp_q.size()); end
            if (prev_fv && !prev_fr) begin
                checks++;
                if (fill_req_valid !== 1'b1 || fill_req_addr !== prev_faddr)
                begin errors++; $display("FAIL wrap_req_hold got=%b/%h exp=1/%h", fill_req_valid, fill_req_addr, prev_faddr); end
            end
            if (prev_rv && !prev_rr) begin
                checks++;
                if (restart_valid !== 1'b1 || restart_addr !== prev_raddr || restart_payload !== prev_rpay || restart_data !== prev_rdata)
                begin errors++; $display("FAIL wrap_restart_hold got=%b/%h exp=1/%h", restart_valid, restart_addr, prev_raddr); end
            end
            if (fill_rsp_valid) void'(busq.pop_front());
            if (fill_req_valid && fill_req_ready) begin
                checks++;
                if (fillq.size() == 0) begin
                    errors++; $display("FAIL wrap_req_unexpected got=%h exp=none", fill_req_addr);
                end else begin
                    a = fillq.pop_front();
                    if (fill_req_addr !== a) begin errors++; $display("FAIL wrap_req_addr got=%h exp=%h", fill_req_addr, a); end
                end
                busq.push_back(fill_req_addr);
            end
            if (enq_valid && enq_ready) begin
                coll = 1'b0;
                if (COLLIDE) foreach (exp_q[k]) if (!exp_q[k].collided && exp_q[k].addr == enq_addr) coll = 1'b1;
                e.addr = enq_addr; e.payload = enq_payload; e.collided = coll;
                exp_q.push_back(e);
                if (!coll) fillq.push_back(enq_addr);
                sent++;
            end
            if (restart_valid && restart_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL wrap_restart_unexpected got=%h exp=none", restart_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (restart_addr !== e.addr || restart_payload !== e.payload || restart_collided !== e.collided ||
                        (!e.collided && restart_data !== line_of(e.addr)))
                    begin errors++; $display("FAIL wrap_restart got=%h/%b exp=%h/%b", restart_addr, restart_collided, e.addr, e.collided); end
                end
                done++;
            end
            prev_fv = fill_req_valid; prev_fr = fill_req_ready; prev_faddr = fill_req_addr;
            prev_rv = restart_valid; prev_rr = restart_ready; prev_raddr = restart_addr;
            prev_rpay = restart_payload; prev_rdata = restart_data;
            @(posedge clk);
            #1;
            cyc++;
        end
        idle_inputs();
        checks++;
        if (done != n) begin errors++; $display("FAIL wrap_timeout got=%0d exp=%0d restarts", done, n); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        enq_valid = 1'b1; enq_addr = 26'h10; enq_payload = rand_payload();
        tick();
        enq_addr = 26'h11; fill_req_ready = 1'b1;
        tick();
        enq_addr = 26'h12; fill_req_ready = 1'b0; fill_rsp_valid = 1'b1; fill_rsp_data = line_of(26'h10);
        tick();
        idle_inputs();
        checks++;
        if (restart_valid !== 1'b1 || fill_req_valid !== 1'b1 || occupancy !== 4'd3)
        begin errors++; $display("FAIL arst_setup got=%b/%b/%0d exp=1/1/3", restart_valid, fill_req_valid, occupancy); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (restart_valid !== 1'b0 || fill_req_valid !== 1'b0 || occupancy !== 4'd0)
        begin errors++; $display("FAIL arst_immediate got=%b/%b/%0d exp=0/0/0", restart_valid, fill_req_valid, occupancy); end
        checks++;
        if (restart_addr !== '0 || restart_data !== '0 || restart_payload !== '0 || fill_req_addr !== '0)
        begin errors++; $display("FAIL arst_data got=%h/%h exp=0/0", restart_addr, fill_req_addr); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++;
        if (enq_ready !== 1'b1 || occupancy !== 4'd0 || fill_req_valid !== 1'b0)
        begin errors++; $display("FAIL arst_release got=%b/%0d/%b exp=1/0/0", enq_ready, occupancy, fill_req_valid); end
        enq_valid = 1'b1; enq_addr = 26'h55; enq_payload = rand_payload();
        tick();
        enq_valid = 1'b0; fill_req_ready = 1'b1;
        checks++;
        if (fill_req_valid !== 1'b1 || fill_req_addr !== 26'h55)
        begin errors++; $display("FAIL arst_fresh_req got=%b/%h exp=1/55", fill_req_valid, fill_req_addr); end
        tick();
        fill_req_ready = 1'b0; fill_rsp_valid = 1'b1; fill_rsp_data = line_of(26'h55);
        tick();
        fill_rsp_valid = 1'b0; restart_ready = 1'b1;
        checks++;
        if (restart_valid !== 1'b1 || restart_addr !== 26'h55)
        begin errors++; $display("FAIL arst_fresh_restart got=%b/%h exp=1/55", restart_valid, restart_addr); end
        tick();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_miss();
        test_full_queue();
        test_collision();
        test_wrap(20, 1'b0);
        test_wrap(30, 1'b1);
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
